burst_addr_issuer: RTL and testbench
====================================

# burst_addr_issuer

Command-driven address generator for the instruction FIFO / memory-load path. It accepts a (base, length) command and emits `length` consecutive addresses starting at `base`, one per cycle, over a valid/ready stream. It is the issuing end of the load-address path: it produces the address sequence that the load-side counters consume, and it signals completion back to the controller.

## Interface
Parameters:
- `COUNTER_WIDTH`, default 32: width of addresses and of the length field.
- `MATRIX_WIDTH`, default 14: carried for package consistency; does not affect behaviour.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `rst_n`  in  1: synchronous, active-low reset.
- `enable`  in  1: global advance. Low freezes all state and masks handshakes.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_base`  in  COUNTER_WIDTH: first address of the burst.
- `cmd_length`  in  COUNTER_WIDTH: number of addresses to issue (0 is legal).
- `addr_valid`  out  1: address present.
- `addr_ready`  in  1: consumer accepts when `addr_valid & addr_ready`.
- `addr`  out  COUNTER_WIDTH: current address.
- `addr_last`  out  1: marks the final address of the burst.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse after burst completion.

## Operation
- State machine with two states, IDLE and ISSUE. Registers: `addr_reg`, `remaining` (COUNTER_WIDTH), `done_reg`.
- `cmd_ready = (state==IDLE) & enable`.
- `addr_valid = (state==ISSUE) & enable`.
- `addr = addr_reg`.
- `addr_last = (state==ISSUE) & (remaining==1)`.
- `busy = (state==ISSUE)`.
- `done = done_reg`.
- IDLE, command handshake with `cmd_length != 0`: `addr_reg <= cmd_base`, `remaining <= cmd_length`, go to ISSUE.
- IDLE, command handshake with `cmd_length == 0`: stay in IDLE, `done_reg <= 1`. No address is issued.
- ISSUE, address handshake: `addr_reg <= addr_reg + 1`, wrapping modulo 2^COUNTER_WIDTH. `remaining <= remaining - 1`.
  - If `remaining == 1`: go to IDLE and set `done_reg <= 1`.
- `done_reg` clears to 0 on every enabled cycle in which it is not set.
- `enable` low:
  - no register changes, including `done_reg`;
  - `cmd_ready` and `addr_valid` are forced to 0, so no handshake can occur.
- `cmd_*` is ignored while `cmd_ready` is 0; commands are never queued.
- `addr_ready` is ignored outside ISSUE.
- Stream rule: `addr`, `addr_last` and `addr_valid` stay stable while `addr_valid & !addr_ready`, given `enable` is held.
- Address arithmetic is unsigned and wraps silently; there is no overflow flag.

## Timing
- Reset (`rst_n` low at a posedge) forces:
  - state IDLE;
  - `addr_reg`, `remaining` and `done_reg` to 0;
  - `addr_valid` 0, `addr` 0, `addr_last` 0, `busy` 0, `done` 0;
  - `cmd_ready` equal to `enable` from the first cycle after reset.
- Reset during ISSUE abandons the burst; no `done` pulse is produced.
- Command accepted at edge T: first address valid in cycle T+1 with `addr == cmd_base`.
- Throughput is one address per cycle while `addr_ready` and `enable` are high.
- Final handshake at edge T: `done` is 1 and `cmd_ready` is 1 in cycle T+1 (one-cycle pulse).
- A new command accepted at T+1 gives its first address at T+2. The gap between bursts is exactly one bubble.
- Zero-length command accepted at T: `done` is 1 in T+1, and `busy` stays 0 throughout.
- `enable` low while `done` is 1 stretches the pulse until the next enabled cycle.
- For `cmd_length == 1`: `addr_last` is 1 on the only address.

## Test plan
- Basic burst:
  - stimulus: reset, then `cmd_base=0x100`, `cmd_length=4`, `addr_ready=1`, `enable=1`;
  - response: addresses 0x100, 0x101, 0x102, 0x103 on consecutive cycles; `addr_last` only on 0x103; `done` pulses one cycle after; `busy` high for exactly 4 cycles.
- Backpressure:
  - stimulus: same command, with `addr_ready` toggling 1,0,0,1,1,0,1;
  - response: each address is held stable while not ready; exactly 4 handshakes occur; no address is skipped or repeated.
- Enable stall:
  - stimulus: `enable` low for 3 cycles in the middle of a burst of length 5;
  - response: `addr_valid` and `cmd_ready` are 0 during the stall; the sequence resumes at the held address; `done` arrives 3 cycles later than in the unstalled case.
- Wrap and zero length:
  - stimulus A: `cmd_base=0xFFFFFFFF`, `cmd_length=2`. Response: 0xFFFFFFFF, then 0x00000000 with `addr_last`.
  - stimulus B: `cmd_length=0`. Response: `done` is 1 in the next cycle; `addr_valid` never rises.
- Back-to-back commands:
  - stimulus: `cmd_valid` held high with `cmd_length=1`, `cmd_base` = 0x10, then 0x20;
  - response: 0x10 in cycle T+1; `cmd_ready` and `done` high in T+2; 0x20 in T+3.
  - Also check `cmd_ready` is 0 during ISSUE and a command presented then is not consumed.
- Reset mid-burst:
  - stimulus: `rst_n` low while addressing the 3rd of 8 addresses;
  - response: all outputs at reset values next cycle; no `done` pulse; a following command of length 2 behaves normally.

Source files
------------

// File: rtl/burst_addr_issuer.sv
// Issues cmd_length consecutive addresses from cmd_base; first address one cycle after command accept.
// Output stream holds while addr_ready is low; enable low freezes all state and blocks both handshakes.
module burst_addr_issuer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int MATRIX_WIDTH  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [COUNTER_WIDTH-1:0] cmd_base,
  input  logic [COUNTER_WIDTH-1:0] cmd_length,
  output logic                     addr_valid,
  input  logic                     addr_ready,
  output logic [COUNTER_WIDTH-1:0] addr,
  output logic                     addr_last,
  output logic                     busy,
  output logic                     done
);

  // MATRIX_WIDTH is kept only so the parameter set matches the rest of the load path.
  localparam int CW = COUNTER_WIDTH + (MATRIX_WIDTH * 0);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   addr_reg, addr_d;
  logic [CW-1:0]   remaining, remaining_d;
  logic            done_reg, done_d;
  logic            cmd_hs, addr_hs, on_last;

  assign cmd_ready  = (state_q == IDLE) & enable;
  assign addr_valid = (state_q == ISSUE) & enable;
  assign addr       = addr_reg;
  assign on_last    = (remaining == CW'(1));
  assign addr_last  = (state_q == ISSUE) & on_last;
  assign busy       = (state_q == ISSUE);
  assign done       = done_reg;
  assign cmd_hs     = cmd_valid & cmd_ready;
  assign addr_hs    = addr_valid & addr_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_reg;
    remaining_d = remaining;
    done_d      = done_reg;
    if (enable) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_hs) begin
            if (cmd_length != '0) begin
              addr_d      = cmd_base;
              remaining_d = cmd_length;
              state_d     = ISSUE;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (addr_hs) begin
            addr_d      = addr_reg + CW'(1);
            remaining_d = remaining - CW'(1);
            if (on_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_reg  <= '0;
      remaining <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_reg  <= addr_d;
      remaining <= remaining_d;
      done_reg  <= done_d;
    end
  end

endmodule

// File: tb/tb_burst_addr_issuer.sv
// Directed bench for burst_addr_issuer: per-scenario tasks with hand-computed expectations.
module tb_burst_addr_issuer;

  logic        clk = 1'b0;
  logic        rst_n, enable, cmd_valid, cmd_ready, addr_valid, addr_ready;
  logic        addr_last, busy, done;
  logic [31:0] cmd_base, cmd_length, addr;

  int checks   = 0;
  int failures = 0;

  burst_addr_issuer #(.COUNTER_WIDTH(32), .MATRIX_WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_length(cmd_length),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr), .addr_last(addr_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_length = '0; addr_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    checks++; if (addr_valid !== 1'b0) begin failures++; $display("FAIL reset_addr_valid got=%b exp=0", addr_valid); end
    checks++; if (addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", addr); end
    checks++; if (addr_last !== 1'b0) begin failures++; $display("FAIL reset_addr_last got=%b exp=0", addr_last); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    enable = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready_dis got=%b exp=0", cmd_ready); end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    cmd_valid = 1'b1; cmd_base = 32'h100; cmd_length = 32'd4; addr_ready = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL basic_cmd_ready got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (addr_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%b exp=1", i, addr_valid); end
      checks++; if (addr !== 32'h100 + i) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr, 32'h100 + i); end
      checks++; if (addr_last !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, addr_last, (i == 3)); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_busy[%0d] got busy=%b done=%b exp busy=1 done=0", i, busy, done); end
      tick();
    end
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0 || addr_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL basic_idle got busy=%b valid=%b cmd_ready=%b exp 0 0 1", busy, addr_valid, cmd_ready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_backpressure();
    logic [6:0] pat;
    logic [31:0] exp_addr;
    int hs;
    pat = 7'b1011001;  // bit k = addr_ready in cycle k: 1,0,0,1,1,0,1
    exp_addr = 32'h100; hs = 0;
    cmd_valid = 1'b1; cmd_base = 32'h100; cmd_length = 32'd4;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      addr_ready = pat[k];
      #1;
      checks++; if (addr_valid !== 1'b1 || addr !== exp_addr) begin
        failures++; $display("FAIL bp_addr[%0d] got valid=%b addr=%h exp valid=1 addr=%h", k, addr_valid, addr, exp_addr); end
      checks++; if (addr_last !== (exp_addr == 32'h103)) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", k, addr_last, (exp_addr == 32'h103)); end
      if (addr_valid && addr_ready) hs++;
      tick();
      if (pat[k]) exp_addr++;
    end
    addr_ready = 1'b1;
    #1;
    checks++; if (hs !== 4) begin failures++; $display("FAIL bp_handshakes got=%0d exp=4", hs); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bp_done got done=%b busy=%b exp 1 0", done, busy); end
    tick();
  endtask

  task automatic test_enable_stall();
    logic [7:0] en;
    logic [31:0] exp_addr;
    en = 8'b11100011;  // bit k = enable in cycle k: 1,1,0,0,0,1,1,1
    exp_addr = 32'h200;
    cmd_valid = 1'b1; cmd_base = 32'h200; cmd_length = 32'd5; addr_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      enable = en[k];
      #1;
      checks++; if (addr_valid !== en[k] || cmd_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hs[%0d] got valid=%b cmd_ready=%b exp valid=%b cmd_ready=0", k, addr_valid, cmd_ready, en[k]); end
      checks++; if (addr !== exp_addr || done !== 1'b0) begin
        failures++; $display("FAIL stall_addr[%0d] got addr=%h done=%b exp addr=%h done=0", k, addr, done, exp_addr); end
      tick();
      if (en[k]) exp_addr++;
    end
    #1;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
    enable = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL stall_done_stretch got done=%b cmd_ready=%b exp 1 0", done, cmd_ready); end
    enable = 1'b1;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL stall_done_clear got=%b exp=0", done); end
  endtask

  task automatic test_wrap_zero();
    cmd_valid = 1'b1; cmd_base = 32'hFFFF_FFFF; cmd_length = 32'd2; addr_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if (addr !== 32'hFFFF_FFFF || addr_last !== 1'b0) begin failures++; $display("FAIL wrap_first got addr=%h last=%b exp ffffffff 0", addr, addr_last); end
    tick();
    checks++; if (addr !== 32'h0 || addr_last !== 1'b1 || addr_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_second got addr=%h last=%b valid=%b exp 00000000 1 1", addr, addr_last, addr_valid); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", done); end
    tick();
    cmd_valid = 1'b1; cmd_base = 32'h55; cmd_length = 32'd0;
    tick();
    cmd_valid = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b busy=%b valid=%b exp 1 0 0", done, busy, addr_valid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || addr_valid !== 1'b0) begin
      failures++; $display("FAIL zero_after got done=%b busy=%b valid=%b exp 0 0 0", done, busy, addr_valid); end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_base = 32'h10; cmd_length = 32'd1; addr_ready = 1'b1;
    tick();
    cmd_base = 32'h20;
    #1;
    checks++; if (addr !== 32'h10 || addr_valid !== 1'b1 || addr_last !== 1'b1 || cmd_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first got addr=%h valid=%b last=%b cmd_ready=%b exp 10 1 1 0", addr, addr_valid, addr_last, cmd_ready); end
    tick();
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b1 || addr_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_gap got cmd_ready=%b done=%b valid=%b exp 1 1 0", cmd_ready, done, addr_valid); end
    tick();
    cmd_valid = 1'b0;
    #1;
    checks++; if (addr !== 32'h20 || addr_valid !== 1'b1 || addr_last !== 1'b1) begin
      failures++; $display("FAIL b2b_second got addr=%h valid=%b last=%b exp 20 1 1", addr, addr_valid, addr_last); end
    tick(); tick();
    // A command offered mid-burst must be dropped, not queued.
    cmd_valid = 1'b1; cmd_base = 32'h30; cmd_length = 32'd3;
    tick();
    cmd_base = 32'h99; cmd_length = 32'd5; addr_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (cmd_ready !== 1'b0 || addr !== 32'h30) begin
        failures++; $display("FAIL b2b_hold[%0d] got cmd_ready=%b addr=%h exp 0 30", k, cmd_ready, addr); end
      tick();
    end
    cmd_valid = 1'b0; addr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (addr !== 32'h30 + k) begin failures++; $display("FAIL b2b_seq[%0d] got=%h exp=%h", k, addr, 32'h30 + k); end
      tick();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    tick();
    checks++; if (addr_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_no_queue got valid=%b busy=%b exp 0 0", addr_valid, busy); end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_base = 32'h400; cmd_length = 32'd8; addr_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    checks++; if (addr !== 32'h402) begin failures++; $display("FAIL rst_mid_third got=%h exp=402", addr); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (addr_valid !== 1'b0 || addr !== 32'h0 || addr_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_outputs got valid=%b addr=%h last=%b busy=%b done=%b cmd_ready=%b exp 0 0 0 0 0 1",
                           addr_valid, addr, addr_last, busy, done, cmd_ready); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done got=%b exp=0", done); end
    cmd_valid = 1'b1; cmd_base = 32'h500; cmd_length = 32'd2;
    tick();
    cmd_valid = 1'b0;
    checks++; if (addr !== 32'h500 || addr_last !== 1'b0) begin failures++; $display("FAIL rst_mid_a0 got addr=%h last=%b exp 500 0", addr, addr_last); end
    tick();
    checks++; if (addr !== 32'h501 || addr_last !== 1'b1) begin failures++; $display("FAIL rst_mid_a1 got addr=%h last=%b exp 501 1", addr, addr_last); end
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rst_mid_done got=%b exp=1", done); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_enable_stall();
    test_wrap_zero();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout sim_time=%0t limit=100000", $time);
    $fatal(1, "timeout");
  end

endmodule
